// File: rtl/f33m_mult_arbiter_if.sv
// Requester handshake and shared-multiplier link of f33m_mult_arbiter.
// slave = arbiter side, master = requesters plus the multiplier.
interface f33m_mult_arbiter_if #(
  parameter int N = 4,
  parameter int W = 582
);
  logic [N-1:0]   req;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   ack;
  logic [W-1:0]   rsp_c;
  logic           rsp_err;
  logic [N-1:0]   grant;
  logic           mult_reset;
  logic [W-1:0]   mult_a;
  logic [W-1:0]   mult_b;
  logic [W-1:0]   mult_c;
  logic           mult_done;

  modport slave (
    input  req, req_a, req_b,
    input  mult_c, mult_done,
    output ack, rsp_c, rsp_err, grant,
    output mult_reset, mult_a, mult_b
  );

  modport master (
    output req, req_a, req_b,
    output mult_c, mult_done,
    input  ack, rsp_c, rsp_err, grant,
    input  mult_reset, mult_a, mult_b
  );
endinterface

// File: rtl/f33m_mult_arbiter.sv
// Round-robin sharing of one GF(3^3M) multiplier among N requesters,
// with a watchdog abort and a completed-operation counter.
module f33m_mult_arbiter #(
  parameter int M       = 97,
  parameter int N       = 4,
  parameter int TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        reset,
  f33m_mult_arbiter_if.slave bus,
  output logic        busy,
  output logic [15:0] op_count
);
  localparam int W  = 6 * M;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [11:0] TO = 12'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [N-1:0]  grant_q;
  logic [N-1:0]  mask_q;
  logic [IW-1:0] rr_q;
  logic [IW-1:0] gidx_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  c_q;
  logic          err_q;
  logic [11:0]   wd_q;

  logic [N-1:0]  elig;
  logic          win_found;
  logic [IW-1:0] win_idx;
  int            j;

  // first eligible index at or after rr_q, wrapping
  always_comb begin
    elig      = bus.req & ~mask_q;
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(rr_q) + k;
      if (j >= N) j = j - N;
      if (!win_found && elig[j]) begin
        win_found = 1'b1;
        win_idx   = IW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (win_found) state_d = LAUNCH;
      LAUNCH: state_d = WAIT;
      WAIT:   if (bus.mult_done || wd_q == TO)
                state_d = RESP;
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q  <= '0;
      mask_q   <= '0;
      rr_q     <= '0;
      gidx_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      err_q    <= 1'b0;
      wd_q     <= '0;
      op_count <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          mask_q <= '0;
          if (win_found) begin
            grant_q <= N'(1) << win_idx;
            gidx_q  <= win_idx;
            a_q     <= bus.req_a[int'(win_idx) * W +: W];
            b_q     <= bus.req_b[int'(win_idx) * W +: W];
          end
        end
        LAUNCH: wd_q <= '0;
        WAIT: begin
          wd_q <= wd_q + 12'd1;
          if (bus.mult_done) begin
            c_q   <= bus.mult_c;
            err_q <= 1'b0;
          end else if (wd_q == TO) begin
            c_q   <= '0;
            err_q <= 1'b1;
          end
        end
        RESP: begin
          rr_q    <= (gidx_q == IW'(N - 1)) ? '0 : gidx_q + 1'b1;
          mask_q  <= grant_q;
          grant_q <= '0;
          if (!err_q) op_count <= op_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // low outside LAUNCH so the multiplier's done level survives until capture
  assign bus.mult_reset = reset | (state_q == LAUNCH);
  assign bus.mult_a     = a_q;
  assign bus.mult_b     = b_q;
  assign bus.grant      = grant_q;
  assign bus.ack        = (state_q == RESP) ? grant_q : '0;
  assign bus.rsp_c      = c_q;
  assign bus.rsp_err    = err_q & (state_q == RESP);
  assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_f33m_mult_arbiter.sv
// Directed and randomized bench for f33m_mult_arbiter with a
// fixed-latency multiplier stand-in and a round-robin reference model.
module tb_f33m_mult_arbiter;
  localparam int M       = 4;
  localparam int N       = 4;
  localparam int TIMEOUT = 15;
  localparam int W       = 6 * M;
  localparam logic [W-1:0] JUNK = W'(64'h5a5a5a5a5a5a5a5a);

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic [15:0] op_count;

  always #5 clk = ~clk;

  f33m_mult_arbiter_if #(.N(N), .W(W)) bus ();

  f33m_mult_arbiter #(.M(M), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  int          checks = 0;
  int          errors = 0;
  int          lat = 5;
  bit          never_done = 1'b0;
  int          mcnt = 0;
  logic [W-1:0] opa [N];
  logic [W-1:0] opb [N];
  int          m_rr = 0;
  logic [15:0] m_cnt = '0;

  // trit-wise GF(3) product as the multiplier stand-in
  function automatic logic [W-1:0] gfmul(logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] c;
    c = '0;
    for (int t = 0; t < W / 2; t++)
      c[2*t +: 2] = 2'((int'(a[2*t +: 2]) * int'(b[2*t +: 2])) % 3);
    return c;
  endfunction

  function automatic logic [W-1:0] rand_elem();
    logic [W-1:0] e;
    e = '0;
    for (int t = 0; t < W / 2; t++)
      e[2*t +: 2] = 2'($urandom_range(0, 2));
    return e;
  endfunction

  function automatic int pick(logic [N-1:0] p, int rr);
    for (int k = 0; k < N; k++)
      if (p[(rr + k) % N]) return (rr + k) % N;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (bus.mult_reset) mcnt <= 0;
    else                mcnt <= mcnt + 1;
  end

  assign bus.mult_done = !never_done && !bus.mult_reset && (mcnt >= lat);
  assign bus.mult_c    = bus.mult_done ? gfmul(bus.mult_a, bus.mult_b) : JUNK;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(int i, logic [W-1:0] a, logic [W-1:0] b);
    opa[i] = a;
    opb[i] = b;
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req[i] = 1'b1;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  // mode 0: drop req at ack, 1: keep req, 2: drop req right after grant
  task automatic do_op(int idx, int gap, int mode);
    int n;
    int exp_n;
    bit exp_err;
    logic [W-1:0] exp_c;
    logic [N-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    n = 0;
    while (bus.grant == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("grant", 64'(bus.grant), 64'(oh));
    check("grant_gap", 64'(n), 64'(gap));
    check("launch_mult_reset", 64'(bus.mult_reset), 64'(1));
    check("busy", 64'(busy), 64'(1));
    check("mult_a", 64'(bus.mult_a), 64'(opa[idx]));
    check("mult_b", 64'(bus.mult_b), 64'(opb[idx]));
    if (mode == 2) bus.req[idx] = 1'b0;
    if (mode != 1) bus.req_a[idx*W +: W] = ~opa[idx];
    @(negedge clk);
    check("wait_mult_reset", 64'(bus.mult_reset), 64'(0));
    exp_err = never_done || (lat > TIMEOUT);
    exp_n   = exp_err ? TIMEOUT + 1 : lat + 1;
    exp_c   = exp_err ? '0 : gfmul(opa[idx], opb[idx]);
    n = 0;
    while (bus.ack == '0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("ack_latency", 64'(n), 64'(exp_n));
    check("ack", 64'(bus.ack), 64'(oh));
    check("rsp_c", 64'(bus.rsp_c), 64'(exp_c));
    check("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
    check("hold_a", 64'(bus.mult_a), 64'(opa[idx]));
    if (mode == 0) bus.req[idx] = 1'b0;
    m_rr = (idx + 1) % N;
    if (!exp_err) m_cnt = m_cnt + 16'd1;
    @(negedge clk);
    check("ack_pulse", 64'(bus.ack), 64'(0));
    check("grant_clear", 64'(bus.grant), 64'(0));
    check("op_count", 64'(op_count), 64'(m_cnt));
  endtask

  initial begin
    int n;
    logic [N-1:0] sub;
    logic [N-1:0] oh;
    reset     = 1'b1;
    bus.req   = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    repeat (3) @(negedge clk);
    check("rst_mult_reset", 64'(bus.mult_reset), 64'(1));
    check("rst_grant", 64'(bus.grant), 64'(0));
    check("rst_ack", 64'(bus.ack), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_op_count", 64'(op_count), 64'(0));
    check("rst_rsp_c", 64'(bus.rsp_c), 64'(0));
    check("rst_rsp_err", 64'(bus.rsp_err), 64'(0));
    check("rst_mult_a", 64'(bus.mult_a), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    check("idle_mult_reset", 64'(bus.mult_reset), 64'(0));

    // all requesters hold req: 0,1,2,3,0
    for (int i = 0; i < N; i++) set_req(i, rand_elem(), rand_elem());
    for (int k = 0; k < 5; k++) begin
      lat = $urandom_range(0, 8);
      do_op(pick(bus.req, m_rr), 1, 1);
    end
    bus.req = '0;
    idle(2);

    // single request, a=1 b=2
    set_req(2, W'(1), W'(2));
    lat = 12;
    do_op(2, 1, 0);
    idle(1);

    // lone requester keeps req past ack: masked IDLE cycle first
    set_req(1, rand_elem(), rand_elem());
    lat = 3;
    do_op(1, 1, 1);
    do_op(1, 2, 0);
    idle(1);

    // randomized request subsets
    repeat (6) begin
      sub = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++)
        if (sub[i]) set_req(i, rand_elem(), rand_elem());
      while (bus.req != '0) begin
        lat = $urandom_range(0, TIMEOUT);
        do_op(pick(bus.req, m_rr), 1, 2 * $urandom_range(0, 1));
      end
      idle(1);
    end

    // watchdog abort, then normal service
    never_done = 1'b1;
    set_req(0, rand_elem(), rand_elem());
    do_op(0, 1, 0);
    never_done = 1'b0;
    set_req(3, rand_elem(), rand_elem());
    lat = 2;
    do_op(3, 1, 0);

    // done on the timeout cycle
    set_req(2, rand_elem(), rand_elem());
    lat = TIMEOUT;
    do_op(2, 1, 0);
    idle(1);

    // reset during WAIT
    set_req(1, rand_elem(), rand_elem());
    set_req(3, rand_elem(), rand_elem());
    lat = 30;
    oh = '0;
    oh[pick(bus.req, m_rr)] = 1'b1;
    n = 0;
    while (bus.grant == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_grant", 64'(bus.grant), 64'(oh));
    idle(3);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ack", 64'(bus.ack), 64'(0));
    check("midrst_grant", 64'(bus.grant), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_op_count", 64'(op_count), 64'(0));
    check("midrst_mult_reset", 64'(bus.mult_reset), 64'(1));
    reset = 1'b0;
    m_rr  = 0;
    m_cnt = '0;
    lat   = 6;
    do_op(pick(bus.req, m_rr), 1, 0);
    do_op(pick(bus.req, m_rr), 1, 0);
    idle(1);

    // op_count wrap
    force dut.op_count = 16'hffff;
    #1;
    release dut.op_count;
    @(negedge clk);
    check("preload", 64'(op_count), 64'hffff);
    m_cnt = 16'hffff;
    set_req(0, rand_elem(), rand_elem());
    lat = 4;
    do_op(0, 1, 0);
    never_done = 1'b1;
    set_req(1, rand_elem(), rand_elem());
    do_op(1, 1, 0);
    never_done = 1'b0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
